// File: rtl/frame_receiver.sv
// frame_receiver: oversampled asynchronous serial frame receiver with a one-frame output holding register
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   rx_in        line level, already synchronized to clk, idle high
//   data_out     received word (LSB first on the line)
//   data_valid   data_out/parity_err/framing_err hold an unconsumed frame
//   data_ready   consumer takes the held frame this cycle
//   parity_err   parity mismatch of the held frame
//   framing_err  a stop bit of the held frame was sampled low
//   overrun_err  one-cycle pulse when a completed frame is dropped
//   busy         receiver is inside a frame
module frame_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 framing_err,
    output logic                 overrun_err,
    output logic                 busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_V    = TW'(OVERSAMPLE / 2 + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 s0_q, s0_d, s1_q, s1_d, rx_prev_q;
    logic                 pe_q, pe_d, fe_q, fe_d;
    logic                 valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic                 vote, at_v, wrap, done, load;

    always_comb begin
        // third sample is the live line at tick M+1, so the vote is ready that same cycle
        vote    = (s0_q & s1_q) | (s0_q & rx_in) | (s1_q & rx_in);
        at_v    = tick_q == T_V;
        wrap    = tick_q == T_LAST;
        s0_d    = tick_q == T_S0 ? rx_in : s0_q;
        s1_d    = tick_q == T_S1 ? rx_in : s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        done    = 1'b0;
        case (state_q)
            S_IDLE: if (rx_prev_q && !rx_in) begin
                state_d = S_START;
                pe_d    = 1'b0;
                fe_d    = 1'b0;
            end
            S_START: if (at_v && vote) state_d = S_IDLE;
                else if (wrap) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            S_DATA: begin
                if (at_v) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    cnt_d   = cnt_q + CW'(1);
                end
                if (wrap && cnt_q == CW'(DATA_BITS)) begin
                    state_d = PARITY != 0 ? S_PAR : S_STOP;
                    cnt_d   = '0;
                end
            end
            S_PAR: begin
                // odd mode errs on even total, even mode errs on odd total
                if (at_v) pe_d = ^shift_q ^ vote ^ (PARITY == 1);
                if (wrap) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                end
            end
            S_STOP: if (at_v) begin
                fe_d  = fe_q | ~vote;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(STOP_BITS - 1)) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // leaving the last stop bit early lets the very next cycle see a start edge
        tick_d  = (state_q == S_IDLE || state_d == S_IDLE || wrap) ? '0 : tick_q + TW'(1);
        load    = done & (~valid_q | data_ready);
        data_d  = load ? shift_q : data_q;
        perr_d  = load ? pe_q : perr_q;
        ferr_d  = load ? fe_d : ferr_q;
        valid_d = load | (valid_q & ~data_ready);
        ovr_d   = done & valid_q & ~data_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            s0_q      <= 1'b0;
            s1_q      <= 1'b0;
            rx_prev_q <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            rx_prev_q <= rx_in;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign parity_err  = perr_q;
    assign framing_err = ferr_q;
    assign overrun_err = ovr_q;
    assign busy        = state_q != S_IDLE;
endmodule

// File: doc/frame_receiver.md
FRAME_RECEIVER -- requirements
Module: frame_receiver

Interface
REQ-001 Parameter DATA_BITS, default 8, SHALL set data bits per frame; legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16, SHALL set clk cycles per bit period; legal range 8..64.
REQ-003 Parameter PARITY, default 0, SHALL select parity mode: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1, SHALL set stop bits per frame; legal values 1 or 2.
REQ-005 clk  input  1  SHALL be the single clock; all state changes on posedge clk.
REQ-006 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 rx_in  input  1  SHALL be the line level, already synchronized to clk; idle high.
REQ-008 data_out  output  DATA_BITS  SHALL carry the received word, LSB first on the line.
REQ-009 data_valid  output  1  SHALL indicate data_out and its status flags hold an unconsumed frame.
REQ-010 data_ready  input  1  SHALL indicate the consumer accepts the frame this cycle.
REQ-011 parity_err  output  1  SHALL flag a parity mismatch for the held frame; 0 when PARITY=0.
REQ-012 framing_err  output  1  SHALL flag any stop bit sampled low for the held frame.
REQ-013 overrun_err  output  1  SHALL pulse for one cycle when a completed frame is dropped.
REQ-014 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-015 Tick counter SHALL count 0..OVERSAMPLE-1 within each bit period, wrap to 0, and hold at 0 in IDLE.
REQ-016 Each bit value SHALL be the majority of three rx_in samples taken at ticks M-1, M, M+1, where M = OVERSAMPLE/2 (integer division).
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE->START SHALL occur on the first cycle rx_in is 0 while rx_in was 1 the previous cycle; tick restarts at 0.
REQ-019 START: a vote of 1 at tick M+1 SHALL return the FSM to IDLE with no output change (glitch rejection); a vote of 0 SHALL continue to DATA at the tick wrap.
REQ-020 DATA SHALL shift in DATA_BITS votes LSB first, then go to PARITY (PARITY!=0) or to STOP.
REQ-021 PARITY: the error SHALL be set when the XOR of the data bits and the parity vote is 0 (odd mode) or 1 (even mode).
REQ-022 STOP SHALL vote STOP_BITS bits; any 0 vote SHALL set framing error for the frame.
REQ-023 The frame SHALL complete at tick M+1 of the last stop bit; the FSM SHALL enter IDLE the next cycle without waiting for the period end, so a start edge is detectable immediately.
REQ-024 On completion with data_valid=0, or with data_valid=1 and data_ready=1 in the same cycle, data_out, parity_err and framing_err SHALL load the new frame and data_valid SHALL be 1 the following cycle.
REQ-025 On completion with data_valid=1 and data_ready=0, the new frame SHALL be discarded, the held frame SHALL be unchanged, and overrun_err SHALL be 1 for exactly the following cycle.
REQ-026 data_valid SHALL clear the cycle after data_ready=1 is sampled with no concurrent completion; data_ready SHALL be ignored while data_valid=0.
REQ-027 A frame with framing or parity error SHALL still be delivered, with its flags set.
REQ-028 The FSM SHALL ignore rx_in edges except in IDLE; no mid-frame resynchronization.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, tick 0, shift register 0, data_out 0, data_valid 0, parity_err 0, framing_err 0, overrun_err 0, busy 0.
REQ-030 Reset asserted mid-frame SHALL abandon the partial frame; after release the FSM SHALL wait for a fresh 1->0 edge.

Verification
REQ-031 Default params, rx frame 0xA5 8N1 at 16 clk/bit -> data_out=0xA5, data_valid=1 one cycle after tick 9 of the stop bit, no error flags.
REQ-032 Low pulse of 5 clk on idle line -> FSM returns to IDLE, data_valid stays 0, busy high for no more than 10 cycles.
REQ-033 PARITY=2, DATA_BITS=7, frame 0x3C sent with a wrong parity bit -> data_out=0x3C, parity_err=1; with a correct parity bit -> parity_err=0.
REQ-034 STOP_BITS=2, second stop bit driven low -> framing_err=1 with correct data_out.
REQ-035 Two back-to-back frames 0x11, 0x22 with data_ready=0 -> data_out stays 0x11 and overrun_err pulses once; repeat with data_ready=1 on the completion cycle -> data_out=0x22, no overrun.
REQ-036 rst_n low at data bit 4 followed by a clean frame 0x5A -> only 0x5A is delivered.
